// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings for the iterative multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Level of busy_o that stalls the pipeline (the `Stop value of stallreq).
  localparam logic BUSY_STOP = 1'b1;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate
module muldiv_signfix #(
  parameter int N = 32
) (
  input  logic         neg_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + N'(1)) : data_i;

endmodule

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - iterative signed/unsigned multiply and restoring divide, one bit per cycle
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             dbz_q, dbz_d;

  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;

  assign op_in = op_e'(op_i);
  assign neg1  = op_is_signed(op_in) & opdata1_i[WIDTH-1];
  assign neg2  = op_is_signed(op_in) & opdata2_i[WIDTH-1];

  muldiv_signfix #(.N(WIDTH)) u_mag1 (.neg_i(neg1), .data_i(opdata1_i), .data_o(mag1));
  muldiv_signfix #(.N(WIDTH)) u_mag2 (.neg_i(neg2), .data_i(opdata2_i), .data_o(mag2));

  // Multiply: acc = {partial hi, remaining multiplier}, shifted right each step.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + ({1'b0, m_q} & {(WIDTH+1){acc_q[0]}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  assign div_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, m_q};
  assign div_rem  = div_ge ? (div_sh[WIDTH-1:0] - m_q) : div_sh[WIDTH-1:0];
  assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

  logic             fix_lo, fix_hi;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign fix_lo = neg_lo_q & op_is_signed(op_q);
  assign fix_hi = neg_hi_q & op_is_signed(op_q);

  muldiv_signfix #(.N(W2))    u_fix_prod (.neg_i(fix_lo), .data_i(acc_q),              .data_o(prod_fix));
  muldiv_signfix #(.N(WIDTH)) u_fix_quo  (.neg_i(fix_lo), .data_i(acc_q[WIDTH-1:0]),   .data_o(quo_fix));
  muldiv_signfix #(.N(WIDTH)) u_fix_rem  (.neg_i(fix_hi), .data_i(acc_q[W2-1:WIDTH]),  .data_o(rem_fix));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          op_d     = op_in;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          neg_lo_d = neg1 ^ neg2;
          neg_hi_d = op_is_div(op_in) & neg1;
          if (op_is_div(op_in)) begin
            m_d   = mag2;
            acc_d = {{WIDTH{1'b0}}, mag1};
          end else begin
            m_d   = mag1;
            acc_d = {{WIDTH{1'b0}}, mag2};
          end
          if (op_is_div(op_in) && (opdata2_i == '0)) begin
            dbz_d    = 1'b1;
            res_hi_d = opdata1_i;
            res_lo_d = '1;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (op_is_div(op_q)) begin
          res_hi_d = rem_fix;
          res_lo_d = quo_fix;
        end else begin
          {res_hi_d, res_lo_d} = prod_fix;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Annul drops the operation and keeps the last delivered result visible.
    if (annul_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end
  end

  assign busy_o        = (state_q != ST_IDLE) ? BUSY_STOP : ~BUSY_STOP;
  assign ready_o       = (state_q == ST_DONE) && !annul_i;
  assign div_by_zero_o = dbz_q;
  assign result_hi_o   = res_hi_q;
  assign result_lo_o   = res_lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// tb/tb_iter_muldiv.sv - self-checking bench for iter_muldiv (32-bit and 8-bit builds)
module tb_iter_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8, annul;
  logic [1:0]  op;
  logic [31:0] d1, d2;
  logic        busy32, ready32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy8, ready8, dbz8;
  logic [7:0]  hi8, lo8;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_hi [2];
  logic [31:0] last_lo [2];
  logic        last_dbz[2];

  always #5 clk = ~clk;

  iter_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op), .opdata1_i(d1), .opdata2_i(d2),
    .annul_i(annul), .busy_o(busy32), .ready_o(ready32), .div_by_zero_o(dbz32),
    .result_hi_o(hi32), .result_lo_o(lo32));

  iter_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op), .opdata1_i(d1[7:0]), .opdata2_i(d2[7:0]),
    .annul_i(annul), .busy_o(busy8), .ready_o(ready8), .div_by_zero_o(dbz8),
    .result_hi_o(hi8), .result_lo_o(lo8));

  // Reference: plain wide integer arithmetic on the w-bit operands.
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a, b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] mask, ua, ub, p, t;
    longint      sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    dz = 1'b0;
    p  = 64'd0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      default: ;
    endcase
    if (!o[1]) begin
      t = (p >> w) & mask; hi = t[31:0];
      t = p & mask;        lo = t[31:0];
    end else if (ub == 0) begin
      dz = 1'b1;
      hi = ua[31:0];
      lo = mask[31:0];
    end else begin
      if (o[0]) begin
        t = ua / ub; lo = t[31:0];
        t = ua % ub; hi = t[31:0];
      end else begin
        q = sa / sb;
        r = sa % sb;
        t = q & mask; lo = t[31:0];
        t = r & mask; hi = t[31:0];
      end
    end
  endfunction

  task automatic exec(input int sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit noise);
    int          w, lat, exp_lat;
    logic [31:0] ehi, elo, h, l;
    logic        edz, rdy, bsy, dz;
    bit          seen;
    w = (sel != 0) ? 8 : 32;
    model(w, o, a, b, ehi, elo, edz);
    exp_lat = edz ? 1 : w + 2;
    op = o; d1 = a; d2 = b;
    if (sel != 0) start8 = 1'b1; else start32 = 1'b1;
    @(negedge clk);
    lat = 1; seen = 0;
    rdy = 1'b0; bsy = 1'b0; dz = 1'b0; h = '0; l = '0;
    while (lat <= 60 && !seen) begin
      if (noise) begin
        if (sel != 0) start8 = 1'b1; else start32 = 1'b1;
        op = 2'($urandom); d1 = $urandom; d2 = $urandom;
      end else begin
        start8 = 1'b0; start32 = 1'b0;
      end
      rdy = (sel != 0) ? ready8 : ready32;
      bsy = (sel != 0) ? busy8 : busy32;
      dz  = (sel != 0) ? dbz8 : dbz32;
      h   = (sel != 0) ? {24'd0, hi8} : hi32;
      l   = (sel != 0) ? {24'd0, lo8} : lo32;
      if (rdy) seen = 1;
      else begin
        n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL busy_run w=%0d lat=%0d: got %b want 1", w, lat, bsy); end
        n_cmp++; if ({h, l} !== {last_hi[sel], last_lo[sel]}) begin n_bad++;
          $display("FAIL hold_run w=%0d lat=%0d: got %h_%h want %h_%h", w, lat, h, l, last_hi[sel], last_lo[sel]); end
        n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL dbz_clear w=%0d lat=%0d: got %b want 0", w, lat, dz); end
        @(negedge clk);
        lat++;
      end
    end
    n_cmp++; if (lat !== exp_lat) begin n_bad++;
      $display("FAIL latency w=%0d op=%0d a=%h b=%h: got %0d want %0d", w, o, a, b, lat, exp_lat); end
    if (seen) begin
      n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL busy_done w=%0d: got %b want 1", w, bsy); end
      n_cmp++; if ({h, l, dz} !== {ehi, elo, edz}) begin n_bad++;
        $display("FAIL result w=%0d op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 w, o, a, b, h, l, dz, ehi, elo, edz); end
    end
    last_hi[sel] = ehi; last_lo[sel] = elo; last_dbz[sel] = edz;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    rdy = (sel != 0) ? ready8 : ready32;
    bsy = (sel != 0) ? busy8 : busy32;
    n_cmp++; if ({rdy, bsy} !== 2'b00) begin n_bad++; $display("FAIL after_done w=%0d: got ready,busy=%b%b want 00", w, rdy, bsy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start32 = 1'b0; start8 = 1'b0; annul = 1'b0; op = 2'b00; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy32, ready32, dbz32} !== 3'b000) begin n_bad++; $display("FAIL reset_flags32: got %b%b%b want 000", busy32, ready32, dbz32); end
    n_cmp++; if ({hi32, lo32} !== 64'd0) begin n_bad++; $display("FAIL reset_result32: got %h_%h want 0", hi32, lo32); end
    n_cmp++; if ({busy8, ready8, dbz8, hi8, lo8} !== 19'd0) begin n_bad++; $display("FAIL reset_dut8: got %b%b%b %h %h want 0", busy8, ready8, dbz8, hi8, lo8); end
    for (int i = 0; i < 2; i++) begin last_hi[i] = '0; last_lo[i] = '0; last_dbz[i] = 1'b0; end
  endtask

  task automatic test_directed();
    exec(0, 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    n_cmp++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mul_neg3x7: got %h_%h want ffffffff_ffffffeb", hi32, lo32); end
    exec(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    exec(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    n_cmp++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL div_neg7by2: got %h_%h want ffffffff_fffffffd", hi32, lo32); end
    exec(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    exec(0, 2'b11, 32'd100, 32'd0, 0);
    n_cmp++; if ({hi32, lo32, dbz32} !== {64'h0000_0064_FFFF_FFFF, 1'b1}) begin n_bad++; $display("FAIL divu_by0: got %h_%h dbz=%b want 00000064_ffffffff dbz=1", hi32, lo32, dbz32); end
  endtask

  task automatic test_annul();
    logic [31:0] ehi, elo;
    logic        edz;
    op = 2'b11; d1 = 32'd100; d2 = 32'd7; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0; last_dbz[0] = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk); annul = 1'b0;
    n_cmp++; if ({busy32, ready32} !== 2'b00) begin n_bad++; $display("FAIL annul_calc: got busy,ready=%b%b want 00", busy32, ready32); end
    n_cmp++; if ({hi32, lo32, dbz32} !== {last_hi[0], last_lo[0], last_dbz[0]}) begin n_bad++; $display("FAIL annul_calc_hold: got %h_%h %b", hi32, lo32, dbz32); end
    exec(0, 2'b11, 32'd100, 32'd7, 0);
    n_cmp++; if ({hi32, lo32} !== 64'h0000_0002_0000_000E) begin n_bad++; $display("FAIL divu_100by7: got %h_%h want 00000002_0000000e", hi32, lo32); end
    // Annul during FIX: result must not be written.
    op = 2'b10; d1 = 32'hFFFF_FF00; d2 = 32'd3; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    repeat (32) @(negedge clk);
    annul = 1'b1;
    @(negedge clk); annul = 1'b0;
    n_cmp++; if ({busy32, ready32, hi32, lo32} !== {2'b00, last_hi[0], last_lo[0]}) begin n_bad++;
      $display("FAIL annul_fix: got %b%b %h_%h want 00 %h_%h", busy32, ready32, hi32, lo32, last_hi[0], last_lo[0]); end
    // Annul in DONE: pulse suppressed, result already written.
    model(32, 2'b01, 32'd5, 32'd6, ehi, elo, edz);
    op = 2'b01; d1 = 32'd5; d2 = 32'd6; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    repeat (33) @(negedge clk);
    n_cmp++; if (ready32 !== 1'b1) begin n_bad++; $display("FAIL done_reached: got ready=%b want 1", ready32); end
    annul = 1'b1; #1;
    n_cmp++; if (ready32 !== 1'b0) begin n_bad++; $display("FAIL annul_done_pulse: got ready=%b want 0", ready32); end
    @(negedge clk); annul = 1'b0;
    last_hi[0] = ehi; last_lo[0] = elo; last_dbz[0] = edz;
    n_cmp++; if ({busy32, hi32, lo32} !== {1'b0, ehi, elo}) begin n_bad++; $display("FAIL annul_done_after: got %b %h_%h want 0 %h_%h", busy32, hi32, lo32, ehi, elo); end
    // Annul together with start in IDLE: start ignored.
    op = 2'b00; d1 = 32'd9; d2 = 32'd9; start32 = 1'b1; annul = 1'b1;
    @(negedge clk); start32 = 1'b0; annul = 1'b0;
    n_cmp++; if ({busy32, hi32, lo32} !== {1'b0, ehi, elo}) begin n_bad++; $display("FAIL annul_start_idle: got %b %h_%h want 0 %h_%h", busy32, hi32, lo32, ehi, elo); end
  endtask

  task automatic test_reset_mid();
    bit pulsed;
    exec(0, 2'b11, 32'd50, 32'd0, 0);
    op = 2'b00; d1 = $urandom; d2 = $urandom; start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pulsed = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready32 || busy32) pulsed = 1;
      @(negedge clk);
    end
    n_cmp++; if (pulsed) begin n_bad++; $display("FAIL reset_mid_activity: got busy/ready after reset want none"); end
    n_cmp++; if ({hi32, lo32, dbz32} !== 65'd0) begin n_bad++; $display("FAIL reset_mid_regs: got %h_%h %b want 0", hi32, lo32, dbz32); end
    last_hi[0] = '0; last_lo[0] = '0; last_dbz[0] = 1'b0;
    last_hi[1] = '0; last_lo[1] = '0; last_dbz[1] = 1'b0;
  endtask

  task automatic test_width8();
    exec(1, 2'b00, 32'h80, 32'hFF, 0);
    n_cmp++; if ({hi8, lo8} !== 16'h0080) begin n_bad++; $display("FAIL mul8_min_x_neg1: got %h_%h want 00_80", hi8, lo8); end
    exec(1, 2'b10, 32'h80, 32'hFF, 0);
    exec(1, 2'b10, 32'hF9, 32'h02, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  o;
    int          sel;
    for (int i = 0; i < 45; i++) begin
      sel = (i >= 32) ? 1 : 0;
      o = 2'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = (sel != 0) ? 32'h80 : 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'd1;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      exec(sel, o, a, b, ($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_annul();
    test_width8();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
